// File: rtl/imm_field_encoder.sv
// Packs a 32-bit immediate into RV32I I/S/B/J/U instruction fields and expands LI
// into ADDI / LUI / LUI+ADDI, behind valid/ready handshakes with one output register.
module imm_field_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    typedef enum logic [1:0] {IDLE, HOLD, HOLD_HI} state_t;

    state_t      state, state_next;
    logic [31:0] instr_q, pend_q;
    logic        err_q, last_q;

    logic        accept, advance_hi;
    logic [31:0] enc_word, enc_second;
    logic        enc_err, enc_last, enc_two;
    logic        fits12, fits13, fits21;
    logic [4:0]  rd;
    logic [19:0] li_hi;

    assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});
    assign rd     = in_base[11:7];
    // Rounds the upper part so the sign-extended ADDI low part lands on the exact value.
    assign li_hi  = in_imm[31:12] + {19'd0, in_imm[11]};

    assign in_ready   = !reset && ((state == IDLE) || (state == HOLD && out_ready));
    assign accept     = in_valid && in_ready;
    assign advance_hi = (state == HOLD_HI) && out_ready;
    assign out_valid  = (state != IDLE);
    assign out_instr  = instr_q;
    assign out_err    = err_q;
    assign out_last   = last_q;

    always_comb begin
        enc_word   = in_base;
        enc_second = 32'd0;
        enc_err    = 1'b0;
        enc_last   = 1'b1;
        enc_two    = 1'b0;
        case (in_fmt)
            3'b000: begin
                enc_word = (in_base & 32'h000F_FFFF) | {in_imm[11:0], 20'd0};
                enc_err  = !fits12;
            end
            3'b001: begin
                enc_word = (in_base & ~32'hFE00_0F80)
                         | {in_imm[11:5], 13'd0, in_imm[4:0], 7'd0};
                enc_err  = !fits12;
            end
            3'b010: begin
                enc_word = (in_base & ~32'hFE00_0F80)
                         | {in_imm[12], in_imm[10:5], 13'd0, in_imm[4:1], in_imm[11], 7'd0};
                enc_err  = !fits13 || in_imm[0];
            end
            3'b011: begin
                enc_word = (in_base & 32'h0000_0FFF)
                         | {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'd0};
                enc_err  = !fits21 || in_imm[0];
            end
            3'b100: begin
                enc_word = (in_base & 32'h0000_0FFF) | {in_imm[31:12], 12'd0};
                enc_err  = |in_imm[11:0];
            end
            3'b101: begin
                enc_second = {in_imm[11:0], rd, 3'b000, rd, 7'b0010011};
                if (fits12) begin
                    enc_word = {in_imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
                end else begin
                    enc_word = {li_hi, rd, 7'b0110111};
                    enc_two  = |in_imm[11:0];
                    enc_last = !(|in_imm[11:0]);
                end
            end
            default: begin
                enc_word = in_base;
                enc_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = enc_two ? HOLD_HI : HOLD;
            end
            HOLD: begin
                if (out_ready) state_next = accept ? (enc_two ? HOLD_HI : HOLD) : IDLE;
            end
            HOLD_HI: begin
                if (out_ready) state_next = HOLD;
            end
            default: state_next = IDLE;
        endcase
    end

    // The pending ADDI is captured on accept so HOLD_HI needs no input stability.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            instr_q <= 32'd0;
            pend_q  <= 32'd0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                instr_q <= enc_word;
                pend_q  <= enc_second;
                err_q   <= enc_err;
                last_q  <= enc_last;
            end else if (advance_hi) begin
                instr_q <= pend_q;
                err_q   <= 1'b0;
                last_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed self-checking bench for imm_field_encoder with hand-computed encodings.
module tb_imm_field_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = 3'd0;
    logic [31:0] in_base = 32'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    int n_checks = 0;
    int n_fail   = 0;

    imm_field_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_base(in_base), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_fmt = 3'd0; in_base = 32'h13; in_imm = 32'd1;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if ({out_instr, out_err, out_last} !== 34'd0) begin n_fail++; $display("[TB] FAIL reset_outputs got %h/%b/%b want 0", out_instr, out_err, out_last); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_fmt = 3'b010; in_base = 32'h0020_8063; in_imm = 32'hFFFF_FFFC;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b_out_valid got %b want 1", out_valid); end
        n_checks++; if ({out_instr, out_err, out_last} !== {32'hFE20_8EE3, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL b_word got %h/%b/%b want fe208ee3/0/1", out_instr, out_err, out_last); end
        in_fmt = 3'b000; in_base = 32'h0000_0093; in_imm = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if ({out_valid, out_instr, out_err, out_last} !== {1'b1, 32'hFFF0_0093, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL i_word got %b/%h/%b/%b want 1/fff00093/0/1", out_valid, out_instr, out_err, out_last); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_li();
        out_ready = 1'b1;
        in_valid = 1'b1; in_fmt = 3'b101; in_base = 32'h0000_0280; in_imm = 32'h1234_5FFF;
        tick();
        // Next request waits while the LUI/ADDI pair drains.
        in_base = 32'h0000_0080; in_imm = 32'd100;
        #1;
        n_checks++; if ({out_valid, out_instr, out_err, out_last} !== {1'b1, 32'h1234_62B7, 1'b0, 1'b0}) begin n_fail++; $display("[TB] FAIL li_lui got %b/%h/%b/%b want 1/123462b7/0/0", out_valid, out_instr, out_err, out_last); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL li_hi_in_ready got %b want 0", in_ready); end
        tick();
        n_checks++; if ({out_valid, out_instr, out_err, out_last} !== {1'b1, 32'hFFF2_8293, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL li_addi got %b/%h/%b/%b want 1/fff28293/0/1", out_valid, out_instr, out_err, out_last); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL li_hold_in_ready got %b want 1", in_ready); end
        tick();
        n_checks++; if ({out_instr, out_err, out_last} !== {32'h0640_0093, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL li_small got %h/%b/%b want 06400093/0/1", out_instr, out_err, out_last); end
        in_base = 32'h0000_0100; in_imm = 32'h1000_0000;
        tick();
        n_checks++; if ({out_instr, out_err, out_last} !== {32'h1000_0137, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL li_lui_only got %h/%b/%b want 10000137/0/1", out_instr, out_err, out_last); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL li_lui_only_in_ready got %b want 1", in_ready); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL li_drain got %b want 0", out_valid); end
    endtask

    task automatic test_formats();
        logic [2:0]  fmt  [9] = '{3'b010, 3'b011, 3'b100, 3'b000, 3'b111, 3'b001, 3'b011, 3'b100, 3'b000};
        logic [31:0] base [9] = '{32'h0020_8063, 32'h0000_006F, 32'h0000_0037, 32'h0000_0013, 32'h0000_0013,
                                  32'h0011_2023, 32'h0000_00EF, 32'h0000_02B7, 32'h0000_0013};
        logic [31:0] imm  [9] = '{32'd5, 32'h0010_0000, 32'd1, 32'd2048, 32'hDEAD_BEEF,
                                  32'd8, 32'h0000_0800, 32'h1234_5000, 32'hFFFF_F800};
        logic [31:0] exp_w[9] = '{32'h0020_8263, 32'h8000_006F, 32'h0000_0037, 32'h8000_0013, 32'h0000_0013,
                                  32'h0011_2423, 32'h0010_00EF, 32'h1234_52B7, 32'h8000_0013};
        logic        exp_e[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_fmt = fmt[i]; in_base = base[i]; in_imm = imm[i];
            tick();
            n_checks++;
            if ({out_valid, out_instr, out_err, out_last} !== {1'b1, exp_w[i], exp_e[i], 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL fmt_vec%0d got %b/%h/%b/%b want 1/%h/%b/1", i, out_valid, out_instr, out_err, out_last, exp_w[i], exp_e[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_fmt = 3'b101; in_base = 32'h0000_0280; in_imm = 32'h1234_5FFF;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++; if ({out_valid, out_instr, out_last} !== {1'b1, 32'h1234_62B7, 1'b0}) begin n_fail++; $display("[TB] FAIL bp_stable%0d got %b/%h/%b want 1/123462b7/0", c, out_valid, out_instr, out_last); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready%0d got %b want 0", c, in_ready); end
            if (c == 0) tick();
        end
        reset = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_reset_valid got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_reset_in_ready got %b want 0", in_ready); end
        reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_no_addi%0d got %b/%h want 0", c, out_valid, out_instr); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_li();
        test_formats();
        test_backpressure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_field_encoder.md
Name: imm_field_encoder

Overview:
- Inverse of the immediate extender: packs a 32-bit immediate into the RV32I instruction-word immediate fields for I, S, B, J and U formats.
- Also expands the LI pseudo-instruction into ADDI, LUI, or LUI+ADDI words.
- Sits between the test-program generator/loader and instruction memory, with valid/ready on both sides and one registered output stage.
- Flags immediates that cannot be represented in the chosen format.

Parameters:
- NONE_RESERVED, 0, reserved; the block has no tunable parameters. Widths are fixed by RV32I.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted on the edge where in_valid && in_ready
- in_fmt  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 LI; 110/111 invalid
- in_base  in  32  template word carrying opcode/rd/funct3/rs1/rs2/funct7; for LI only [11:7] (rd) is used
- in_imm  in  32  immediate value (byte offset for B/J; full value for U/LI)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts on the edge where out_valid && out_ready
- out_instr  out  32  encoded instruction word
- out_err  out  1  immediate not representable, or invalid format
- out_last  out  1  final word of the current request

Behaviour:
- Reset: state IDLE; out_valid=0, out_instr=0, out_err=0, out_last=0. in_ready=0 while reset is high.
- Reset mid-operation: any held word or pending second LI word is discarded. No output follows reset.
- FSM states:
  - IDLE: no word held.
  - HOLD: word held with out_last=1.
  - HOLD_HI: LUI held, ADDI pending.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- Accept gives a 1-cycle latency: out_valid rises on the edge after acceptance. Throughput is 1 request/cycle when no LI expansion occurs.
- Transitions:
  - IDLE + accept -> HOLD, or HOLD_HI for 2-word LI.
  - HOLD + out_ready, no new accept -> IDLE.
  - HOLD + out_ready + accept -> HOLD/HOLD_HI with the new word.
  - HOLD_HI + out_ready -> HOLD with the ADDI word; in_ready=0 throughout HOLD_HI.
- While out_valid && !out_ready: out_instr, out_err and out_last are held stable.
- Non-LI formats: out_instr = in_base with the format's immediate bit positions cleared, then filled:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Range checks set out_err=1; the word is still emitted using the truncated bits:
  - I/S: imm outside -2048..2047.
  - B: imm outside -4096..4094, or imm[0]=1.
  - J: imm outside -1048576..1048574, or imm[0]=1.
  - U: imm[11:0]!=0.
- in_fmt 110/111: out_instr=in_base, out_err=1, out_last=1.
- LI (rd=in_base[11:7]), never errors:
  - If imm is in -2048..2047: single word ADDI rd,x0,imm = {imm[11:0],5'd0,3'b000,rd,7'b0010011}.
  - Otherwise: hi=(imm+32'h800)[31:12], with 32-bit wrap-around. Emit LUI {hi,rd,7'b0110111}.
  - If imm[11:0]!=0: LUI has out_last=0, followed by ADDI {imm[11:0],rd,3'b000,rd,7'b0010011} with out_last=1.
  - If imm[11:0]==0: LUI only, with out_last=1.

Test Plan:
- Reset with in_valid=1 -> in_ready=0, out_valid=0. Release reset -> in_ready=1, out_valid=0 until the first accept.
- B, base 0x00208063, imm 0xFFFFFFFC, out_ready=1 -> next cycle out_instr=0xFE208EE3, out_err=0, out_last=1. Back-to-back I request is accepted the same cycle.
- LI, rd=5, imm 0x12345FFF, out_ready=1 -> 0x123462B7 (out_last=0), then 0xFFF28293 (out_last=1). in_ready=0 during the first word.
- LI rd=1, imm 100 -> single 0x06400093. LI rd=2, imm 0x10000000 -> single 0x10000137, out_last=1.
- Error cases, all with word still emitted and out_err=1:
  - B imm=5 (odd).
  - J imm=0x00100000.
  - U imm=0x00000001.
  - I imm=2048.
  - in_fmt=111 with base 0x00000013 -> out_instr=0x00000013.
- Backpressure: out_ready=0 for 3 cycles during LI HOLD_HI -> LUI word stable, in_ready=0. Assert reset in cycle 2 -> out_valid=0 next cycle, ADDI never emitted.
